// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: A - B - bin computed LSB first through one
// full-subtractor cell, with valid/ready handshakes on both the operand and result sides.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
  output logic             ovf_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sd;
  logic             br;
  logic [CW-1:0]    cnt;
  // Operand sign bits survive the shifting so the overflow flag can use them.
  logic             a_msb;
  logic             b_msb;

  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] sd_next;

  assign d       = sa[0] ^ sb[0] ^ br;
  assign br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  assign sd_next = {d, sd[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sa          <= '0;
      sb          <= '0;
      sd          <= '0;
      br          <= 1'b0;
      cnt         <= '0;
      a_msb       <= 1'b0;
      b_msb       <= 1'b0;
      diff_out    <= '0;
      borrow_out  <= 1'b0;
      ovf_out     <= 1'b0;
      out_valid   <= 1'b0;
      start_ready <= 1'b1;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid && start_ready) begin
            sa          <= a_in;
            sb          <= b_in;
            br          <= bin;
            cnt         <= '0;
            a_msb       <= a_in[WIDTH-1];
            b_msb       <= b_in[WIDTH-1];
            state       <= RUN;
            start_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end
        RUN: begin
          sa <= sa >> 1;
          sb <= sb >> 1;
          sd <= sd_next;
          br <= br_next;
          if (cnt == CW'(WIDTH - 1)) begin
            state      <= DONE;
            diff_out   <= sd_next;
            borrow_out <= br_next;
            // The final serial bit d is the difference MSB.
            ovf_out    <= (a_msb != b_msb) && (d != a_msb);
            out_valid  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (WIDTH=8) with hand-computed results.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic       bin = 1'b0;
  logic [7:0] diff_out;
  logic       borrow_out;
  logic       ovf_out;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy;

  int checks = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .a_in(a_in), .b_in(b_in), .bin(bin),
    .diff_out(diff_out), .borrow_out(borrow_out), .ovf_out(ovf_out),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accepts one operand set and waits (bounded) for out_valid; returns cycles from accept.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        output int lat);
    a_in = a; b_in = b; bin = bi; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    a_in = 8'hAA; b_in = 8'h55; bin = 1'b1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic bi, input logic [7:0] ed, input logic eb, input logic eo);
    int lat;
    launch(a, b, bi, lat);
    check({tag, "_lat"}, 32'(lat), 32'd8);
    check({tag, "_diff"}, 32'(diff_out), 32'(ed));
    check({tag, "_borrow"}, 32'(borrow_out), 32'(eb));
    check({tag, "_ovf"}, 32'(ovf_out), 32'(eo));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(start_ready), 32'd1);
    $display("op %s: a=0x%02h b=0x%02h bin=%0d -> diff=0x%02h borrow=%0d ovf=%0d",
             tag, a, b, bi, ed, eb, eo);
  endtask

  initial begin
    int lat;
    #12;
    check("rst_diff", 32'(diff_out), 32'd0);
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_valid_busy", {30'd0, out_valid, busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("t1",  8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
    run_op("t2",  8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    run_op("t3",  8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("t4a", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
    run_op("t4b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("t5",  8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1);

    // Backpressure: hold out_ready low, poke start_valid during DONE.
    launch(8'hC3, 8'h21, 1'b0, lat);
    check("bp_lat", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      start_valid = (i == 2);
      a_in = 8'h11; b_in = 8'h22;
      @(posedge clk); #1;
      start_valid = 1'b0;
      check("bp_hold_diff", 32'(diff_out), 32'hA2);
      check("bp_hold_flags", {29'd0, out_valid, borrow_out, ovf_out}, 32'b100);
      check("bp_start_ready", 32'(start_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_valid_drop", 32'(out_valid), 32'd0);
    check("bp_ready_back", 32'(start_ready), 32'd1);
    @(posedge clk); #1;
    check("bp_no_new_op", {30'd0, busy, out_valid}, 32'd0);
    check("bp_diff_kept", 32'(diff_out), 32'hA2);
    $display("op bp: a=0xc3 b=0x21 bin=0 -> diff=0xa2 held 5 cycles");

    // Reset after the 3rd RUN bit.
    a_in = 8'h5A; b_in = 8'h3C; bin = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_diff", 32'(diff_out), 32'd0);
    check("mid_rst_flags", {28'd0, out_valid, busy, borrow_out, ovf_out}, 32'd0);
    check("mid_rst_start_ready", 32'(start_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("post_rst_no_valid", 32'(out_valid), 32'd0);
    end
    check("post_rst_start_ready", 32'(start_ready), 32'd1);
    $display("op rst: reset mid-RUN discarded operation");
    run_op("t6", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
